// File: rtl/int_to_fp32.sv
// ---------------------------------------------------------------------------
// int_to_fp32
//
// Multi-cycle converter from a 32-bit two's-complement integer to an IEEE 754
// single-precision word. The magnitude is normalised one bit per cycle and
// then rounded once. One conversion is held in flight; both sides use
// valid/ready handshakes.
//
// Parameters:
//   ROUND_MODE  0 = round-to-nearest-even, 1 = truncate toward zero
//   BIAS        exponent bias added to the unbiased exponent
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data valid
//   in_ready   converter can accept an operand (IDLE only)
//   in_data    signed two's-complement integer
//   out_valid  result valid, held until consumed (DONE only)
//   out_ready  consumer accepts result
//   result     IEEE 754 single {sign, exp[7:0], mant[22:0]}
//   inexact    result differs from the exact integer; qualified by out_valid
//
// State table:
//   state | meaning
//   IDLE  | waiting for an operand, in_ready=1
//   NORM  | shifting mag left until mag[31]=1 (or mag==0)
//   ROUND | round the 24-bit significand and register the result
//   DONE  | result presented, out_valid=1, waiting for out_ready
// ---------------------------------------------------------------------------
module int_to_fp32 #(
    parameter int ROUND_MODE = 0,
    parameter int BIAS       = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent of a value whose leading one sits at bit 31.
    localparam logic [7:0] EXP_INIT = 8'(BIAS + 31);

    state_t      state_q,   state_d;
    logic [31:0] mag_q,     mag_d;
    logic [7:0]  exp_q,     exp_d;
    logic        sign_q,    sign_d;
    logic [31:0] result_q,  result_d;
    logic        inexact_q, inexact_d;

    // Rounding fields, only meaningful while in ROUND (mag_q[31]=1 there).
    logic [22:0] mant_f;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [22:0] mant_rnd;
    logic [7:0]  exp_rnd;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= 32'd0;
            exp_q     <= 8'd0;
            sign_q    <= 1'b0;
            result_q  <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = NORM;
            end
            NORM: begin
                if (mag_q == 32'd0)  state_d = DONE;
                else if (mag_q[31])  state_d = ROUND;
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Rounding
    // -----------------------------------------------------------------------
    always_comb begin
        mant_f   = mag_q[30:8];
        guard    = mag_q[7];
        sticky   = |mag_q[6:0];
        round_up = (ROUND_MODE == 0) && guard && (sticky || mant_f[0]);
        mant_sum = {1'b0, mant_f} + {23'd0, round_up};
        // A carry out of the 23-bit fraction means the significand reached
        // 2.0: the fraction wraps to zero and the exponent steps up. The
        // largest input exponent here is BIAS+30, so this cannot overflow.
        if (mant_sum[23]) begin
            mant_rnd = 23'd0;
            exp_rnd  = exp_q + 8'd1;
        end else begin
            mant_rnd = mant_sum[22:0];
            exp_rnd  = exp_q;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[31];
                    // -2^31 negates to itself, which is the correct
                    // unsigned magnitude 0x80000000.
                    mag_d  = in_data[31] ? (~in_data + 32'd1) : in_data;
                    exp_d  = EXP_INIT;
                end
            end
            NORM: begin
                if (mag_q == 32'd0) begin
                    // Zero is always +0, whatever sign was latched.
                    result_d  = 32'd0;
                    inexact_d = 1'b0;
                end else if (!mag_q[31]) begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            ROUND: begin
                result_d  = {sign_q, exp_rnd, mant_rnd};
                inexact_d = guard | sticky;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = result_q;
        inexact   = inexact_q;
    end

endmodule

// File: tb/tb_int_to_fp32.sv
// ---------------------------------------------------------------------------
// tb_int_to_fp32
//
// Two converters share one stimulus stream: u_rne (ROUND_MODE=0) and
// u_trn (ROUND_MODE=1). Their timing is identical, so every vector checks
// both rounding modes at once.
// ---------------------------------------------------------------------------
module tb_int_to_fp32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0,  in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] result0,    result1;
    logic        inexact0,   inexact1;

    int checks;
    int errors;

    int_to_fp32 #(.ROUND_MODE(0), .BIAS(127)) u_rne (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .result    (result0),
        .inexact   (inexact0)
    );

    int_to_fp32 #(.ROUND_MODE(1), .BIAS(127)) u_trn (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .result    (result1),
        .inexact   (inexact1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp_rne;
        logic [31:0] exp_trn;
        logic        exp_inx;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic start(input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_timeout", {31'd0, out_valid0}, 32'd1);
        chk("valid_match", {31'd0, out_valid1}, {31'd0, out_valid0});
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("hs_out_valid", {31'd0, out_valid0}, 32'd0);
    endtask

    task automatic convert(input vec_t v);
        int lat;
        start(v.din);
        wait_done(lat);
        chk($sformatf("lat_%h", v.din), 32'(lat), 32'(v.lat));
        chk($sformatf("rne_%h", v.din), result0, v.exp_rne);
        chk($sformatf("trn_%h", v.din), result1, v.exp_trn);
        chk($sformatf("inx_rne_%h", v.din), {31'd0, inexact0}, {31'd0, v.exp_inx});
        chk($sformatf("inx_trn_%h", v.din), {31'd0, inexact1}, {31'd0, v.exp_inx});
        chk("busy_in_ready", {31'd0, in_ready0}, 32'd0);
        handshake();
    endtask

    initial begin
        int  spurious;
        vec_t v;
        checks = 0;
        errors = 0;

        //          din           rne           trn           inx  lat
        vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 33};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 33};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 1'b0, 2};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[5]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 1'b1, 3};
        vecs[6]  = '{32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001, 1'b1, 9};
        vecs[7]  = '{32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000, 1'b1, 9};
        vecs[8]  = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF, 1'b0, 10};
        vecs[9]  = '{32'hFEFF_FFFD, 32'hCB80_0002, 32'hCB80_0001, 1'b1, 9};
        vecs[10] = '{32'h0000_0005, 32'h40A0_0000, 32'h40A0_0000, 1'b0, 31};
        vecs[11] = '{32'h0000_0003, 32'h4040_0000, 32'h4040_0000, 1'b0, 32};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_result", result0, 32'd0);
        chk("rst_inexact", {31'd0, inexact0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) convert(vecs[i]);

        // Backpressure: hold DONE for 10 cycles while in_valid pulses.
        begin
            int lat;
            start(32'h7FFF_FFFF);
            wait_done(lat);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = $urandom;
                @(posedge clk);
                #1;
                chk("bp_out_valid", {31'd0, out_valid0}, 32'd1);
                chk("bp_result", result0, 32'h4F00_0000);
                chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
            end
            in_valid = 1'b0;
            handshake();
            chk("bp_result_kept", result0, 32'h4F00_0000);
            convert(vecs[10]);
        end

        // Asynchronous reset in the middle of NORM for in_data=1.
        start(32'h0000_0001);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("arst_result", result0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid0 || out_valid1) spurious++;
        end
        chk("arst_spurious", 32'(spurious), 32'd0);
        v = '{32'h0000_0005, 32'h40A0_0000, 32'h40A0_0000, 1'b0, 31};
        convert(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
